itof: RTL and testbench

//   Pipelined signed 32-bit integer to IEEE-754 single conversion, rounding to nearest even.
//   It is the inverse of the ftoi unit and provides the FPU's fcvt.s.w path.

---
 rtl/itof.sv | 164 ++++++++++++++++
 tb/tb_itof.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/itof.sv
// itof: pipelined signed/unsigned 32-bit integer to IEEE-754 single, round-to-nearest-even.
// Latency: 3 cycles, input sampled at edge N gives out_valid/out_f after edge N+3; 1 per cycle.
// Backpressure: none; valid-only stream, consumer must take every out_valid pulse.
// Optional feature: define ITOF_INEXACT_EN to add the out_inexact port.
module itof #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_i,
  input  logic        input_valid,
  output logic [31:0] out_f,
  output logic        out_valid
`ifdef ITOF_INEXACT_EN
  ,
  output logic        out_inexact
`endif
);

  // Stage 1 state: sign and absolute magnitude
  logic        s1_vld;
  logic        s1_sign;
  logic [31:0] s1_mag;
  logic        s1_sign_d;
  logic [31:0] s1_mag_d;

  // Stage 2 state: normalized magnitude (hidden bit dropped) and biased exponent
  logic        s2_vld;
  logic        s2_sign;
  logic        s2_zero;
  logic [7:0]  s2_exp;
  logic [30:0] s2_norm;
  logic [4:0]  lzc;
  logic [31:0] s2_norm_d;

  // Stage 3 state: truncated mantissa plus rounding decision
  logic        s3_vld;
  logic        s3_sign;
  logic        s3_zero;
  logic [7:0]  s3_exp;
  logic [22:0] s3_mant;
  logic        s3_rnd;
  logic        s3_guard;
  logic        s3_sticky;

  logic [30:0] rounded;
  logic [31:0] result;

  // Sign select and two's-complement negate; -2^31 naturally yields 32'h8000_0000
  always_comb begin
    s1_sign_d = SIGNED ? in_i[31] : 1'b0;
    s1_mag_d  = s1_sign_d ? (~in_i + 32'd1) : in_i;
  end

  // Stage 1 register; data loads only on a valid input so idle X never propagates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= 32'h0;
    end else begin
      s1_vld <= input_valid;
      if (input_valid) begin
        s1_sign <= s1_sign_d;
        s1_mag  <= s1_mag_d;
      end
    end
  end

  // Leading-zero count: the highest set bit wins because it is visited last
  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (s1_mag[i]) lzc = 5'(31 - i);
    end
    s2_norm_d = s1_mag << lzc;
  end

  // Stage 2 register; a normalized value always has bit31 set, so its absence means zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_sign <= 1'b0;
      s2_zero <= 1'b0;
      s2_exp  <= 8'h0;
      s2_norm <= 31'h0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_sign <= s1_sign;
        s2_zero <= ~s2_norm_d[31];
        s2_exp  <= 8'd158 - {3'b000, lzc};
        s2_norm <= s2_norm_d[30:0];
      end
    end
  end

  // Guard and sticky extraction for nearest-even
  always_comb begin
    s3_guard  = s2_norm[7];
    s3_sticky = |s2_norm[6:0];
  end

  // Stage 3 register; round up on guard with either sticky or an odd mantissa
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld  <= 1'b0;
      s3_sign <= 1'b0;
      s3_zero <= 1'b0;
      s3_exp  <= 8'h0;
      s3_mant <= 23'h0;
      s3_rnd  <= 1'b0;
    end else begin
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_sign <= s2_sign;
        s3_zero <= s2_zero;
        s3_exp  <= s2_exp;
        s3_mant <= s2_norm[30:8];
        s3_rnd  <= s3_guard & (s3_sticky | s2_norm[8]);
      end
    end
  end

  // Rounding increment across {exp,mant}: a mantissa carry-out bumps the exponent
  always_comb begin
    rounded = {s3_exp, s3_mant} + {30'h0, s3_rnd};
    result  = s3_zero ? 32'h0000_0000 : {s3_sign, rounded};
  end

  // Output register; out_f holds between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_f     <= 32'h0;
    end else begin
      out_valid <= s3_vld;
      if (s3_vld) out_f <= result;
    end
  end

`ifdef ITOF_INEXACT_EN
  logic s3_inx;

  // Inexact flag travels alongside stage 3 data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_inx <= 1'b0;
    end else if (s2_vld) begin
      s3_inx <= s3_guard | s3_sticky;
    end
  end

  // Inexact output is forced low whenever no result is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_inexact <= 1'b0;
    end else begin
      out_inexact <= s3_vld & s3_inx;
    end
  end
`endif

endmodule

// File: tb/tb_itof.sv
// Bench for itof: vector table, hand sequences (burst, reset flush) and random scoreboard.
// Two instances (SIGNED=1 and SIGNED=0) share the same stimulus.
// Reference model rounds with plain integer quotient/remainder arithmetic.
module tb_itof;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_i;
  logic        input_valid;
  logic [31:0] out_f_s, out_f_u;
  logic        out_valid_s, out_valid_u;
`ifdef ITOF_INEXACT_EN
  logic        inx_s, inx_u;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] q_in[$];
  int          q_cyc[$];

  itof #(.SIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_i(in_i), .input_valid(input_valid),
    .out_f(out_f_s), .out_valid(out_valid_s)
`ifdef ITOF_INEXACT_EN
    , .out_inexact(inx_s)
`endif
  );

  itof #(.SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_i(in_i), .input_valid(input_valid),
    .out_f(out_f_u), .out_valid(out_valid_u)
`ifdef ITOF_INEXACT_EN
    , .out_inexact(inx_u)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer value, rounded to 24 significant bits by quotient/remainder
  function automatic logic [31:0] ref_conv(input logic [31:0] x, input bit sgn, output bit inx);
    longint sx, m, q, rem, half;
    int e, sh;
    bit s;
    sx = sgn ? longint'($signed(x)) : longint'({32'h0, x});
    s = (sx < 0);
    m = s ? -sx : sx;
    inx = 1'b0;
    if (m == 0) return 32'h0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh = e - 23;
      q = m >> sh;
      rem = m - (q << sh);
      half = longint'(1) << (sh - 1);
      inx = (rem != 0);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {s, 8'(e + 127), q[22:0]};
  endfunction

  // Record each accepted input with the edge it was sampled on
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && input_valid) begin
      q_in.push_back(in_i);
      q_cyc.push_back(cyc);
    end
  end

  // Scoreboard: compare every result against the model and check latency 3
  always @(negedge clk) begin
    logic [31:0] x;
    int c;
    bit inx_es, inx_eu;
    if (!rst_n) begin
      q_in.delete();
      q_cyc.delete();
    end else begin
      chk("valid_match", {31'h0, out_valid_u}, {31'h0, out_valid_s});
      if (out_valid_s) begin
        if (q_in.size() == 0) begin
          chk("unexpected_valid", 32'h1, 32'h0);
        end else begin
          x = q_in.pop_front();
          c = q_cyc.pop_front();
          chk("latency", cyc, c + 3);
          chk("sb_signed", out_f_s, ref_conv(x, 1'b1, inx_es));
          chk("sb_unsigned", out_f_u, ref_conv(x, 1'b0, inx_eu));
`ifdef ITOF_INEXACT_EN
          chk("sb_inx_s", {31'h0, inx_s}, {31'h0, inx_es});
          chk("sb_inx_u", {31'h0, inx_u}, {31'h0, inx_eu});
`endif
        end
      end else if (q_cyc.size() > 0 && q_cyc[0] + 3 <= cyc) begin
        chk("missing_valid", 32'h0, 32'h1);
        void'(q_in.pop_front());
        void'(q_cyc.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] d);
    input_valid = v;
    in_i = v ? d : 32'hxxxx_xxxx;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic        inx;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tbl[0] = '{32'd0,          32'h0000_0000, 1'b0};
    tbl[1] = '{32'd1,          32'h3F80_0000, 1'b0};
    tbl[2] = '{32'hFFFF_FFFF,  32'hBF80_0000, 1'b0};
    tbl[3] = '{32'd100,        32'h42C8_0000, 1'b0};
    tbl[4] = '{32'd16777217,   32'h4B80_0000, 1'b1};
    tbl[5] = '{32'd16777219,   32'h4B80_0002, 1'b1};
    tbl[6] = '{32'd16777218,   32'h4B80_0001, 1'b0};
    tbl[7] = '{32'h7FFF_FFFF,  32'h4F00_0000, 1'b1};
    tbl[8] = '{32'h8000_0000,  32'hCF00_0000, 1'b0};

    rst_n = 1'b0;
    input_valid = 1'b0;
    in_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'h0, out_valid_s}, 32'h0);
    chk("reset_out_f", out_f_s, 32'h0);
`ifdef ITOF_INEXACT_EN
    chk("reset_inexact", {31'h0, inx_s}, 32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors: each result appears exactly 3 edges after sampling
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].din);
      drive(1'b0, 32'h0);
      drive(1'b0, 32'h0);
      chk("tbl_early_valid", {31'h0, out_valid_s}, 32'h0);
      drive(1'b0, 32'h0);
      chk("tbl_valid", {31'h0, out_valid_s}, 32'h1);
      chk("tbl_out_f", out_f_s, tbl[i].dout);
`ifdef ITOF_INEXACT_EN
      chk("tbl_inexact", {31'h0, inx_s}, {31'h0, tbl[i].inx});
`endif
      drive(1'b0, 32'h0);
      chk("tbl_pulse", {31'h0, out_valid_s}, 32'h0);
      chk("tbl_hold", out_f_s, tbl[i].dout);
    end

    // Unsigned path: all-ones is 2^32-1, rounds to 2^32
    drive(1'b1, 32'hFFFF_FFFF);
    repeat (3) drive(1'b0, 32'h0);
    chk("unsigned_max", out_f_u, 32'h4F80_0000);
    chk("unsigned_max_s", out_f_s, 32'hBF80_0000);

    // Back-to-back burst of three
    drive(1'b1, 32'd5);
    drive(1'b1, 32'hFFFF_FFF9);
    drive(1'b1, 32'h4000_0000);
    drive(1'b0, 32'h0);
    chk("burst_v0", {31'h0, out_valid_s}, 32'h1);
    chk("burst_d0", out_f_s, 32'h40A0_0000);
    drive(1'b0, 32'h0);
    chk("burst_v1", {31'h0, out_valid_s}, 32'h1);
    chk("burst_d1", out_f_s, 32'hC0E0_0000);
    drive(1'b0, 32'h0);
    chk("burst_v2", {31'h0, out_valid_s}, 32'h1);
    chk("burst_d2", out_f_s, 32'h4E80_0000);
    drive(1'b0, 32'h0);
    chk("burst_end", {31'h0, out_valid_s}, 32'h0);

    // Reset with two items in flight discards them
    drive(1'b1, 32'd10);
    drive(1'b1, 32'd20);
    input_valid = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0);
      chk("flush_valid", {31'h0, out_valid_s}, 32'h0);
    end
    drive(1'b1, 32'd3);
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
    chk("post_rst_early", {31'h0, out_valid_s}, 32'h0);
    drive(1'b0, 32'h0);
    chk("post_rst_valid", {31'h0, out_valid_s}, 32'h1);
    chk("post_rst_out_f", out_f_s, 32'h4040_0000);

    // Random stream with gaps, checked by the scoreboard
    n = 0;
    while (n < 1000) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 32'h0);
      end else begin
        drive(1'b1, $urandom >> $urandom_range(0, 31) ^ ($urandom_range(0, 1) != 0 ? 32'hFFFF_FFFF : 32'h0));
        n++;
      end
    end
    repeat (6) drive(1'b0, 32'h0);
    chk("drain", q_in.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
